// File: rtl/tug_of_war_ctrl.sv
// Tug of War round/score controller: arbitrates press pulses, walks a one-hot
// rope light, detects round wins, holds off between rounds and ends the match.
module tug_of_war_ctrl #(
  parameter int unsigned NUM_LEDS = 9,
  parameter int unsigned SCORE_W  = 3,
  parameter int unsigned HOLDOFF  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                L_press,
  input  logic                R_press,
  output logic [NUM_LEDS-1:0] leds,
  output logic [1:0]          winner,
  output logic [SCORE_W-1:0]  score_L,
  output logic [SCORE_W-1:0]  score_R,
  output logic                game_over
);

  localparam int unsigned PosW = $clog2(NUM_LEDS);
  localparam int unsigned CntW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [PosW-1:0]    Centre   = PosW'(NUM_LEDS / 2);
  localparam logic [PosW-1:0]    LeftEnd  = PosW'(NUM_LEDS - 1);
  localparam logic [CntW-1:0]    HoldLast = CntW'(HOLDOFF - 1);
  localparam logic [SCORE_W-1:0] MaxScore = '1;
  localparam logic [SCORE_W-1:0] Penult   = MaxScore - 1'b1;

  typedef enum logic [1:0] {StPlay, StWinHold, StOver} state_e;

  state_e              state_q;
  logic [PosW-1:0]     pos_q;
  logic [CntW-1:0]     cnt_q;
  logic [NUM_LEDS-1:0] leds_q;
  logic [1:0]          winner_q;
  logic [SCORE_W-1:0]  score_l_q;
  logic [SCORE_W-1:0]  score_r_q;
  logic                over_q;

  // Simultaneous presses cancel each other.
  logic move_l, move_r;
  assign move_l = L_press & ~R_press;
  assign move_r = R_press & ~L_press;

  function automatic logic [NUM_LEDS-1:0] onehot(input logic [PosW-1:0] p);
    logic [NUM_LEDS-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StPlay;
      pos_q     <= Centre;
      cnt_q     <= '0;
      leds_q    <= onehot(Centre);
      winner_q  <= 2'b00;
      score_l_q <= '0;
      score_r_q <= '0;
      over_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StPlay: begin
          if (move_l) begin
            if (pos_q == LeftEnd) begin
              winner_q  <= 2'b10;
              score_l_q <= score_l_q + 1'b1;
              leds_q    <= '0;
              cnt_q     <= '0;
              over_q    <= (score_l_q == Penult);
              state_q   <= (score_l_q == Penult) ? StOver : StWinHold;
            end else begin
              pos_q  <= pos_q + 1'b1;
              leds_q <= onehot(pos_q + 1'b1);
            end
          end else if (move_r) begin
            if (pos_q == '0) begin
              winner_q  <= 2'b01;
              score_r_q <= score_r_q + 1'b1;
              leds_q    <= '0;
              cnt_q     <= '0;
              over_q    <= (score_r_q == Penult);
              state_q   <= (score_r_q == Penult) ? StOver : StWinHold;
            end else begin
              pos_q  <= pos_q - 1'b1;
              leds_q <= onehot(pos_q - 1'b1);
            end
          end
        end
        StWinHold: begin
          if (cnt_q == HoldLast) begin
            state_q  <= StPlay;
            pos_q    <= Centre;
            leds_q   <= onehot(Centre);
            winner_q <= 2'b00;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StOver: begin
          // Frozen until reset.
          leds_q <= '0;
          over_q <= 1'b1;
        end
        default: state_q <= StPlay;
      endcase
    end
  end

  assign leds      = leds_q;
  assign winner    = winner_q;
  assign score_L   = score_l_q;
  assign score_R   = score_r_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Bench for tug_of_war_ctrl: game-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_tug_of_war_ctrl;

  localparam int N    = 9;
  localparam int SW   = 3;
  localparam int HO   = 4;
  localparam int MAXS = 7;

  logic          clk;
  logic          reset;
  logic          L_press;
  logic          R_press;
  logic [N-1:0]  leds;
  logic [1:0]    winner;
  logic [SW-1:0] score_L;
  logic [SW-1:0] score_R;
  logic          game_over;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Game model: position, scores, remaining hold-off cycles, match-over flag.
  int m_pos, m_sl, m_sr, m_hold, m_win;
  bit m_over;

  tug_of_war_ctrl #(
    .NUM_LEDS(N),
    .SCORE_W (SW),
    .HOLDOFF (HO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .L_press  (L_press),
    .R_press  (R_press),
    .leds     (leds),
    .winner   (winner),
    .score_L  (score_L),
    .score_R  (score_R),
    .game_over(game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_leds();
    logic [N-1:0] v;
    v = '0;
    if (!m_over && m_hold == 0) v[m_pos] = 1'b1;
    return v;
  endfunction

  task automatic model_init();
    m_pos  = N / 2;
    m_sl   = 0;
    m_sr   = 0;
    m_hold = 0;
    m_win  = 0;
    m_over = 1'b0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      model_init();
    end else if (!m_over) begin
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) begin
          m_pos = N / 2;
          m_win = 0;
        end
      end else if (L_press && !R_press) begin
        if (m_pos == N - 1) begin
          m_sl++;
          m_win = 2;
          if (m_sl == MAXS) m_over = 1'b1;
          else m_hold = HO;
        end else begin
          m_pos++;
        end
      end else if (R_press && !L_press) begin
        if (m_pos == 0) begin
          m_sr++;
          m_win = 1;
          if (m_sr == MAXS) m_over = 1'b1;
          else m_hold = HO;
        end else begin
          m_pos--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_leds",      32'(leds),      32'(exp_leds()));
      check("model_winner",    32'(winner),    32'(m_win));
      check("model_score_L",   32'(score_L),   32'(m_sl));
      check("model_score_R",   32'(score_R),   32'(m_sr));
      check("model_game_over", 32'(game_over), 32'(m_over));
    end
  end

  task automatic cyc(input logic rst, input logic l, input logic r);
    reset   = rst;
    L_press = l;
    R_press = r;
    @(negedge clk);
  endtask

  initial begin
    model_init();
    reset   = 1'b1;
    L_press = 1'b0;
    R_press = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Reset state
    check("rst_leds",      32'(leds),      32'h010);
    check("rst_winner",    32'(winner),    32'h0);
    check("rst_score_L",   32'(score_L),   32'h0);
    check("rst_score_R",   32'(score_R),   32'h0);
    check("rst_game_over", 32'(game_over), 32'h0);

    // Left walks to the end; end alone is not a win
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    check("walk_left_end_leds", 32'(leds),   32'h100);
    check("walk_left_end_win",  32'(winner), 32'h0);
    cyc(1'b0, 1'b1, 1'b0);
    check("left_win_leds",   32'(leds),    32'h0);
    check("left_win_winner", 32'(winner),  32'h2);
    check("left_win_score",  32'(score_L), 32'h1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("hold_still_dark", 32'(leds), 32'h0);
    cyc(1'b0, 1'b0, 1'b0);
    check("hold_end_leds",   32'(leds),   32'h010);
    check("hold_end_winner", 32'(winner), 32'h0);

    // Simultaneous presses cancel; right wins
    cyc(1'b0, 1'b1, 1'b1);
    check("cancel_leds", 32'(leds), 32'h010);
    repeat (5) cyc(1'b0, 1'b0, 1'b1);
    check("right_win_winner", 32'(winner),  32'h1);
    check("right_win_score",  32'(score_R), 32'h1);

    // Presses during hold-off are ignored
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    check("hold_press_leds", 32'(leds),    32'h0);
    check("hold_press_sL",   32'(score_L), 32'h1);
    cyc(1'b0, 1'b1, 1'b0);
    check("hold_exit_leds", 32'(leds), 32'h010);
    cyc(1'b0, 1'b0, 1'b0);
    check("no_queue_leds", 32'(leds), 32'h010);

    // Reset mid-round
    repeat (2) cyc(1'b0, 1'b0, 1'b1);
    check("mid_round_leds", 32'(leds), 32'h004);
    cyc(1'b1, 1'b0, 1'b0);
    check("mid_rst_leds",   32'(leds),    32'h010);
    check("mid_rst_sL",     32'(score_L), 32'h0);
    check("mid_rst_sR",     32'(score_R), 32'h0);
    check("mid_rst_winner", 32'(winner),  32'h0);
    cyc(1'b0, 1'b0, 1'b0);

    // Right wins the match
    for (int k = 0; k < MAXS; k++) begin
      repeat (5) cyc(1'b0, 1'b0, 1'b1);
      if (k < MAXS - 1) repeat (4) cyc(1'b0, 1'b0, 1'b0);
    end
    check("over_score_R", 32'(score_R),   32'h7);
    check("over_flag",    32'(game_over), 32'h1);
    check("over_leds",    32'(leds),      32'h0);
    check("over_winner",  32'(winner),    32'h1);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    repeat (6) cyc(1'b0, 1'b0, 1'b1);
    check("frozen_score_R", 32'(score_R),   32'h7);
    check("frozen_score_L", 32'(score_L),   32'h0);
    check("frozen_flag",    32'(game_over), 32'h1);
    check("frozen_leds",    32'(leds),      32'h0);
    cyc(1'b1, 1'b0, 1'b0);
    check("post_rst_leds", 32'(leds),      32'h010);
    check("post_rst_flag", 32'(game_over), 32'h0);
    check("post_rst_sR",   32'(score_R),   32'h0);

    // Random presses, occasional reset; the per-cycle model check covers these
    for (int i = 0; i < 600; i++) begin
      logic l, r, rs;
      l  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 199) == 0);
      cyc(rs, l, r);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
